cart_bus_arbiter: RTL and testbench
===================================

Name: cart_bus_arbiter

Overview:
- Shares the external cartridge bus (address, bidirectional data, rd/wr/cs strobes) between two requesters: the emulated core and a debug/loader port (UART-driven memory peek/poke).
- Sequences each access through setup/strobe/hold phases and returns read data.
- The core has priority; a defer counter guarantees the debug port is not starved.
- Sits between the core and the top-level pin drivers; top-level inverts the strobes and tri-states the data bus from bus_oe.

Parameters:
- SETUP_CYCLES, 1, clocks the address is stable before the strobe (1..15)
- STROBE_CYCLES, 2, clocks rd/wr is asserted (1..15)
- HOLD_CYCLES, 1, clocks the address/data are held after the strobe (1..15)
- MAX_DEFER, 4, consecutive core grants allowed while dbg_req is pending (1..15)

Ports:
- clk  in  1  single system clock
- rst  in  1  synchronous, active-low reset
- core_req  in  1  core access request; level, held until core_done
- core_we  in  1  1=write, 0=read
- core_addr  in  16  core address
- core_wdata  in  8  core write data
- core_rdata  out  8  read data; valid while core_done=1, then held
- core_done  out  1  one-clock completion pulse
- dbg_req, dbg_we, dbg_addr[16], dbg_wdata[8]  in  debug request; same rules as core
- dbg_rdata  out  8  debug read data
- dbg_ack  out  1  one-clock completion pulse
- bus_a  out  16  cartridge address
- bus_dout  out  8  write data to pins
- bus_din  in  8  data from pins
- bus_oe  out  1  drive bus_dout onto pins
- bus_rd  out  1  read strobe (active high)
- bus_wr  out  1  write strobe (active high)
- bus_cs  out  1  RAM select (active high)
- owner  out  1  0=core, 1=debug (current/last grant)

Behaviour:
- Reset (rst=0 at an edge): state IDLE. bus_a=0, bus_dout=0. bus_oe, bus_rd, bus_wr, bus_cs, core_done, dbg_ack all 0. rdata registers 0, owner=0, defer count 0. Reset mid-access aborts it: no done/ack is issued and the strobes drop on the next edge.
- FSM: IDLE -> SETUP -> STROBE -> HOLD -> DONE -> IDLE. Phase counter loads N-1 on phase entry and advances at 0.
- IDLE: sample requests.
  - Only one request: grant it.
  - Both requesting: grant core unless defer==MAX_DEFER, in which case grant debug.
  - On grant, latch addr/we/wdata/owner, and set bus_a, bus_cs=(addr[15:13]==3'b101), and bus_oe=we.
- SETUP: SETUP_CYCLES clocks, strobes low.
- STROBE: STROBE_CYCLES clocks with bus_rd=!we, bus_wr=we. On a read, bus_din is captured at the last STROBE edge into the owner's rdata register.
- HOLD: HOLD_CYCLES clocks. Strobes low; bus_a, bus_cs and bus_oe held.
- DONE: one clock. bus_oe=0, bus_cs=0, bus_a holds. core_done or dbg_ack=1 per owner. Requests are not sampled in DONE; the requester must drop or renew its req by the next IDLE.
- Latency: with req high at IDLE edge t0, done is high during cycle t0+1+S+T+H. With defaults that is t0+5. Back-to-back period is S+T+H+2 = 6 clocks.
- Defer counter:
  - +1 (saturating at MAX_DEFER) on each core grant while dbg_req=1.
  - Cleared on a debug grant, or whenever dbg_req=0 in IDLE.
- The latched request is immune to input changes after grant. A req dropped mid-access still completes and pulses done.
- core_rdata/dbg_rdata are unchanged by writes and by the other requester's reads.

Decomposition:
- Package cart_bus_pkg:
  - ADDR_W=16, DATA_W=8
  - state enum {IDLE, SETUP, STROBE, HOLD, DONE}
  - OWNER_CORE=0, OWNER_DBG=1
  - CS decode constants (RAM_SEL_HI=3'b101)
- Sub-module cart_phase_counter: 4-bit down-counter with load/zero flag, reused for all three phases.

Test Plan:
- Core read, defaults: core_req=1, we=0, addr=16'hA123, bus_din=8'h5C.
  - Expect: bus_cs=1 cycles 1-4; bus_rd=1 cycles 2-3; core_done=1 at cycle 5 only; core_rdata=8'h5C; bus_oe=0 throughout.
- Debug write: dbg_req=1, we=1, addr=16'h2000, wdata=8'h07.
  - Expect: bus_oe=1 cycles 1-4; bus_wr=1 cycles 2-3; bus_cs=0; dbg_ack at cycle 5; owner=1.
- Starvation guard: core_req and dbg_req held high continuously.
  - Expect: grant order core×4, debug, core×4, debug; dbg_ack every 5th completion.
- Simultaneous single requests with defer=0: core wins; the debug access starts exactly 6 clocks after the core grant.
- Reset mid-access: rst=0 during STROBE.
  - Expect next edge: bus_rd=0, bus_cs=0, state IDLE, no core_done; after release, a held req restarts the full sequence.
- Timing parameters S=3, T=1, H=2: read done at t0+7, bus_rd high exactly 1 cycle; req dropped after grant still yields core_done.

Source files
------------

// File: rtl/cart_bus_pkg.sv
// Shared types and constants for the cartridge bus arbiter.
// The address decode for the RAM chip select lives here so the arbiter and any bench agree on it.
package cart_bus_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int PH_W   = 4;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_DBG  = 1'b1;

  localparam logic [2:0] RAM_SEL_HI = 3'b101;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic ram_sel(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: 3] == RAM_SEL_HI;
  endfunction
endpackage

// File: rtl/cart_bus_arbiter_if.sv
// Requester and cartridge-pin signals of the arbiter.
// master = requesters/pin side, slave = the arbiter itself.
interface cart_bus_arbiter_if;
  import cart_bus_pkg::*;

  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_done;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic [ADDR_W-1:0] bus_a;
  logic [DATA_W-1:0] bus_dout;
  logic [DATA_W-1:0] bus_din;
  logic              bus_oe;
  logic              bus_rd;
  logic              bus_wr;
  logic              bus_cs;
  logic              owner;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, bus_din,
    input  core_rdata, core_done, dbg_rdata, dbg_ack,
    input  bus_a, bus_dout, bus_oe, bus_rd, bus_wr, bus_cs, owner
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, bus_din,
    output core_rdata, core_done, dbg_rdata, dbg_ack,
    output bus_a, bus_dout, bus_oe, bus_rd, bus_wr, bus_cs, owner
  );
endinterface

// File: rtl/cart_phase_counter.sv
// Down-counter timing the setup/strobe/hold phases; loaded with N-1 on phase entry.
module cart_phase_counter
  import cart_bus_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PH_W-1:0] load_val,
  output logic            zero
);
  logic [PH_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)             cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - PH_W'(1);
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/cart_bus_arbiter.sv
// Two-requester cartridge bus arbiter: core has priority, debug port is guaranteed
// a slot after MAX_DEFER consecutive core grants. Each access runs setup/strobe/hold/done.
module cart_bus_arbiter
  import cart_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1,
  parameter int MAX_DEFER     = 4
) (
  input  logic               clk,
  input  logic               rst,
  cart_bus_arbiter_if.slave  bus
);
  localparam logic [PH_W-1:0] SETUP_LD  = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0] STROBE_LD = PH_W'(STROBE_CYCLES - 1);
  localparam logic [PH_W-1:0] HOLD_LD   = PH_W'(HOLD_CYCLES - 1);
  localparam logic [PH_W-1:0] DEFER_MAX = PH_W'(MAX_DEFER);

  state_t            state, state_nxt;
  req_t              req_q, req_in;
  logic              owner_q, cs_q;
  logic [PH_W-1:0]   defer_q;
  logic [DATA_W-1:0] core_rdata_q, dbg_rdata_q;
  logic              grant_core, grant_dbg, max_defer;
  logic              ph_load, ph_zero, in_access;
  logic [PH_W-1:0]   ph_val;

  assign max_defer  = (defer_q == DEFER_MAX);
  assign grant_dbg  = bus.dbg_req && (!bus.core_req || max_defer);
  assign grant_core = bus.core_req && !grant_dbg;

  always_comb begin
    req_in = '{we: bus.core_we, addr: bus.core_addr, wdata: bus.core_wdata};
    if (grant_dbg) req_in = '{we: bus.dbg_we, addr: bus.dbg_addr, wdata: bus.dbg_wdata};
  end

  cart_phase_counter u_phase (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val (ph_val),
    .zero     (ph_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ph_load   = 1'b0;
    ph_val    = '0;
    case (state)
      IDLE:   if (grant_core || grant_dbg) begin
                state_nxt = SETUP;  ph_load = 1'b1; ph_val = SETUP_LD;
              end
      SETUP:  if (ph_zero) begin
                state_nxt = STROBE; ph_load = 1'b1; ph_val = STROBE_LD;
              end
      STROBE: if (ph_zero) begin
                state_nxt = HOLD;   ph_load = 1'b1; ph_val = HOLD_LD;
              end
      HOLD:   if (ph_zero) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      req_q        <= '0;
      owner_q      <= OWNER_CORE;
      cs_q         <= 1'b0;
      defer_q      <= '0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      if (state == IDLE) begin
        if (grant_core || grant_dbg) begin
          req_q   <= req_in;
          owner_q <= grant_dbg;
          cs_q    <= ram_sel(req_in.addr);
        end
        // defer only grows while debug is actually waiting behind the core
        if (grant_dbg || !bus.dbg_req)     defer_q <= '0;
        else if (grant_core && !max_defer) defer_q <= defer_q + PH_W'(1);
      end
      if (state == STROBE && ph_zero && !req_q.we) begin
        if (owner_q == OWNER_DBG) dbg_rdata_q  <= bus.bus_din;
        else                      core_rdata_q <= bus.bus_din;
      end
    end
  end

  assign in_access      = (state == SETUP) || (state == STROBE) || (state == HOLD);
  assign bus.bus_a      = req_q.addr;
  assign bus.bus_dout   = req_q.wdata;
  assign bus.bus_oe     = in_access && req_q.we;
  assign bus.bus_cs     = in_access && cs_q;
  assign bus.bus_rd     = (state == STROBE) && !req_q.we;
  assign bus.bus_wr     = (state == STROBE) && req_q.we;
  assign bus.core_done  = (state == DONE) && (owner_q == OWNER_CORE);
  assign bus.dbg_ack    = (state == DONE) && (owner_q == OWNER_DBG);
  assign bus.owner      = owner_q;
  assign bus.core_rdata = core_rdata_q;
  assign bus.dbg_rdata  = dbg_rdata_q;
endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Bench for cart_bus_arbiter: two instances (default timing and S=3/T=1/H=2) share stimulus;
// a transaction-level model predicts every output each cycle, directed cases pin literal timings.
module tb_cart_bus_arbiter;
  logic        clk, rst;
  logic        core_req, core_we, dbg_req, dbg_we;
  logic [15:0] core_addr, dbg_addr;
  logic [7:0]  core_wdata, dbg_wdata, bus_din;

  logic        o_rd[2], o_wr[2], o_cs[2], o_oe[2], o_done[2], o_ack[2], o_own[2];
  logic [15:0] o_a[2];
  logic [7:0]  o_dout[2], o_crd[2], o_drd[2];

  int ps[2] = '{1, 3};
  int pt[2] = '{2, 1};
  int ph[2] = '{1, 2};
  localparam int MAXD = 4;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cart_bus_arbiter_if bif ();
    cart_bus_arbiter #(
      .SETUP_CYCLES  (g == 0 ? 1 : 3),
      .STROBE_CYCLES (g == 0 ? 2 : 1),
      .HOLD_CYCLES   (g == 0 ? 1 : 2),
      .MAX_DEFER     (4)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
    );
    assign bif.core_req   = core_req;
    assign bif.core_we    = core_we;
    assign bif.core_addr  = core_addr;
    assign bif.core_wdata = core_wdata;
    assign bif.dbg_req    = dbg_req;
    assign bif.dbg_we     = dbg_we;
    assign bif.dbg_addr   = dbg_addr;
    assign bif.dbg_wdata  = dbg_wdata;
    assign bif.bus_din    = bus_din;
    assign o_rd[g]   = bif.bus_rd;
    assign o_wr[g]   = bif.bus_wr;
    assign o_cs[g]   = bif.bus_cs;
    assign o_oe[g]   = bif.bus_oe;
    assign o_done[g] = bif.core_done;
    assign o_ack[g]  = bif.dbg_ack;
    assign o_own[g]  = bif.owner;
    assign o_a[g]    = bif.bus_a;
    assign o_dout[g] = bif.bus_dout;
    assign o_crd[g]  = bif.core_rdata;
    assign o_drd[g]  = bif.dbg_rdata;
  end

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Transaction model: an access is a grant time plus a cycle offset into it.
  bit          started = 0;
  bit          m_busy[2], m_we[2], m_cs[2], m_own[2];
  int          m_cyc[2], m_def[2];
  logic [15:0] m_addr[2];
  logic [7:0]  m_dout[2], m_crd[2], m_drd[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit gd;
      if (!rst) begin
        m_busy[i] = 0; m_cyc[i] = 0; m_def[i] = 0; m_we[i] = 0; m_cs[i] = 0; m_own[i] = 0;
        m_addr[i] = '0; m_dout[i] = '0; m_crd[i] = '0; m_drd[i] = '0;
      end else if (!m_busy[i]) begin
        if (core_req || dbg_req) begin
          gd = dbg_req && (!core_req || m_def[i] == MAXD);
          m_busy[i] = 1; m_cyc[i] = 1; m_own[i] = gd;
          m_we[i]   = gd ? dbg_we : core_we;
          m_addr[i] = gd ? dbg_addr : core_addr;
          m_dout[i] = gd ? dbg_wdata : core_wdata;
          m_cs[i]   = (m_addr[i] >= 16'hA000) && (m_addr[i] <= 16'hBFFF);
          if (gd)           m_def[i] = 0;
          else if (dbg_req) m_def[i] = (m_def[i] + 1 > MAXD) ? MAXD : m_def[i] + 1;
          else              m_def[i] = 0;
        end else m_def[i] = 0;
      end else begin
        if (m_cyc[i] == ps[i] + pt[i] && !m_we[i]) begin
          if (m_own[i]) m_drd[i] = bus_din;
          else          m_crd[i] = bus_din;
        end
        if (m_cyc[i] == ps[i] + pt[i] + ph[i] + 1) m_busy[i] = 0;
        else                                     m_cyc[i]++;
      end
    end
    if (!rst) started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        int c;
        bit stb, acc, dn;
        c   = m_cyc[i];
        stb = m_busy[i] && c > ps[i] && c <= ps[i] + pt[i];
        acc = m_busy[i] && c <= ps[i] + pt[i] + ph[i];
        dn  = m_busy[i] && c == ps[i] + pt[i] + ph[i] + 1;
        chk("bus_rd", i, o_rd[i], stb && !m_we[i]);
        chk("bus_wr", i, o_wr[i], stb && m_we[i]);
        chk("bus_cs", i, o_cs[i], acc && m_cs[i]);
        chk("bus_oe", i, o_oe[i], acc && m_we[i]);
        chk("core_done", i, o_done[i], dn && !m_own[i]);
        chk("dbg_ack", i, o_ack[i], dn && m_own[i]);
        chk("owner", i, o_own[i], m_own[i]);
        chk("bus_a", i, o_a[i], m_addr[i]);
        chk("bus_dout", i, o_dout[i], m_dout[i]);
        chk("core_rdata", i, o_crd[i], m_crd[i]);
        chk("dbg_rdata", i, o_drd[i], m_drd[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int done_at[2], ack_at[2], ncs[2], nrd[2], nwr[2], noe[2];

  // Runs ncyc cycles from the grant edge, counting strobes; inst0 completions drop the request.
  task automatic measure(input int ncyc);
    for (int i = 0; i < 2; i++) begin
      done_at[i] = 0; ack_at[i] = 0; ncs[i] = 0; nrd[i] = 0; nwr[i] = 0; noe[i] = 0;
    end
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        ncs[i] += int'(o_cs[i]); nrd[i] += int'(o_rd[i]);
        nwr[i] += int'(o_wr[i]); noe[i] += int'(o_oe[i]);
        if (o_done[i] && done_at[i] == 0) done_at[i] = c;
        if (o_ack[i] && ack_at[i] == 0)   ack_at[i] = c;
      end
      if (o_done[0]) core_req = 0;
      if (o_ack[0])  dbg_req  = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int seq[10];
    int n;
    rst = 0; core_req = 0; core_we = 0; dbg_req = 0; dbg_we = 0;
    core_addr = '0; dbg_addr = '0; core_wdata = '0; dbg_wdata = '0; bus_din = '0;
    repeat (3) tick();
    chk("rst_owner", 0, o_own[0], 0);
    chk("rst_bus_a", 0, o_a[0], 16'h0000);
    chk("rst_rdata", 0, o_crd[0], 8'h00);
    rst = 1;
    tick();

    // core read in the RAM window
    core_req = 1; core_we = 0; core_addr = 16'hA123; bus_din = 8'h5C;
    measure(12);
    chk("rd_done_cyc", 0, done_at[0], 5);
    chk("rd_cs_cnt",   0, ncs[0], 4);
    chk("rd_rd_cnt",   0, nrd[0], 2);
    chk("rd_oe_cnt",   0, noe[0], 0);
    chk("rd_data",     0, o_crd[0], 8'h5C);
    chk("rd_done_cyc", 1, done_at[1], 7);
    chk("rd_rd_cnt",   1, nrd[1], 1);
    chk("rd_cs_cnt",   1, ncs[1], 6);
    chk("rd_data",     1, o_crd[1], 8'h5C);

    // debug write outside the RAM window
    dbg_req = 1; dbg_we = 1; dbg_addr = 16'h2000; dbg_wdata = 8'h07; bus_din = 8'hEE;
    measure(12);
    chk("wr_ack_cyc", 0, ack_at[0], 5);
    chk("wr_oe_cnt",  0, noe[0], 4);
    chk("wr_wr_cnt",  0, nwr[0], 2);
    chk("wr_cs_cnt",  0, ncs[0], 0);
    chk("wr_owner",   0, o_own[0], 1);
    chk("wr_dout",    0, o_dout[0], 8'h07);
    chk("wr_keep_rd", 0, o_crd[0], 8'h5C);
    chk("wr_ack_cyc", 1, ack_at[1], 7);

    // both held: four core grants, then debug
    core_req = 1; core_we = 0; core_addr = 16'h1234;
    dbg_req = 1;  dbg_we = 0;  dbg_addr = 16'hB000;
    n = 0;
    for (int c = 0; c < 90 && n < 10; c++) begin
      tick();
      bus_din = 8'($urandom);
      if (o_done[0] || o_ack[0]) begin
        seq[n] = int'(o_ack[0]);
        n++;
      end
    end
    core_req = 0; dbg_req = 0;
    chk("starve_cnt", 0, n, 10);
    for (int k = 0; k < 10; k++) chk("grant_order", k, seq[k], (k % 5 == 4) ? 1 : 0);
    repeat (16) tick();

    // simultaneous requests with defer cleared: debug granted 6 clocks after core
    core_req = 1; core_we = 0; core_addr = 16'h0400;
    dbg_req = 1;  dbg_we = 0;  dbg_addr = 16'hA800; bus_din = 8'h91;
    measure(20);
    chk("sim_core_cyc", 0, done_at[0], 5);
    chk("sim_dbg_cyc",  0, ack_at[0], 11);
    chk("sim_core_cyc", 1, done_at[1], 7);
    chk("sim_dbg_cyc",  1, ack_at[1], 15);
    chk("sim_dbg_data", 0, o_drd[0], 8'h91);

    // reset during strobe aborts the access; held request restarts it
    core_req = 1; core_we = 0; core_addr = 16'hA000; bus_din = 8'h33;
    tick(); tick();
    chk("rst_pre_rd", 0, o_rd[0], 1);
    rst = 0;
    tick();
    chk("rst_rd",   0, o_rd[0], 0);
    chk("rst_cs",   0, o_cs[0], 0);
    chk("rst_done", 0, o_done[0], 0);
    chk("rst_crd",  0, o_crd[0], 8'h00);
    rst = 1;
    measure(10);
    chk("restart_done", 0, done_at[0], 5);
    chk("restart_done", 1, done_at[1], 7);
    chk("restart_data", 0, o_crd[0], 8'h33);

    // random traffic, checked by the model every cycle
    for (int c = 0; c < 400; c++) begin
      tick();
      rst        = ($urandom_range(0, 99) != 0);
      core_req   = ($urandom_range(0, 2) != 0);
      core_we    = 1'($urandom_range(0, 1));
      core_addr  = 16'($urandom);
      core_wdata = 8'($urandom);
      dbg_req    = ($urandom_range(0, 2) != 0);
      dbg_we     = 1'($urandom_range(0, 1));
      dbg_addr   = 16'($urandom);
      dbg_wdata  = 8'($urandom);
      bus_din    = 8'($urandom);
    end
    rst = 1; core_req = 0; dbg_req = 0;
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
